// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and an optional first-word-fall-through read port.
module fifo_sync_param #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter bit          FWFT       = 1'b0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [FIFO_WIDTH-1:0]              data_in,
  input  logic                               wr_en,
  input  logic                               rd_en,
  output logic [FIFO_WIDTH-1:0]              data_out,
  output logic                               wr_ack,
  output logic                               overflow,
  output logic                               underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               full,
  output logic                               almostfull,
  output logic                               half_full,
  output logic                               almostempty,
  output logic                               empty
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [FIFO_WIDTH-1:0] data_q;
  logic [FIFO_WIDTH-1:0] head_c;
  logic                  rd_acc;
  logic                  wr_acc;

  // Pointers wrap explicitly so any depth works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO still takes a write when the head is popped in the same cycle.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
    head_c = mem[rd_ptr];
  end

  always_comb begin
    full        = (count == CW'(FIFO_DEPTH));
    empty       = (count == '0);
    almostfull  = (count >= CW'(AF_LEVEL)) && !full;
    half_full   = (count >= CW'(FIFO_DEPTH / 2));
    almostempty = (count <= CW'(AE_LEVEL)) && !empty;
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && rst_n) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_q    <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_inc(rd_ptr);
        data_q <= head_c;
      end
      count     <= count + CW'(wr_acc) - CW'(rd_acc);
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  // FWFT shows the head word live; when empty it falls back to the last popped word.
  if (FWFT) begin : g_fwft
    assign data_out = empty ? data_q : head_c;
  end else begin : g_std
    assign data_out = data_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboarded bench for fifo_sync_param: a standard-read 8x16 instance and an FWFT 5x16 instance.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: depth 8, standard read
  logic [15:0] din_a, dout_a;
  logic        wr_a, rd_a, ack_a, ovf_a, unf_a, full_a, af_a, hf_a, ae_a, emp_a;
  logic [3:0]  cnt_a;

  // Instance B: depth 5, first-word-fall-through
  logic [15:0] din_b, dout_b;
  logic        wr_b, rd_b, ack_b, ovf_b, unf_b, full_b, af_b, hf_b, ae_b, emp_b;
  logic [2:0]  cnt_b;

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1), .FWFT(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(din_a), .wr_en(wr_a), .rd_en(rd_a), .data_out(dout_a),
    .wr_ack(ack_a), .overflow(ovf_a), .underflow(unf_a), .count(cnt_a), .full(full_a),
    .almostfull(af_a), .half_full(hf_a), .almostempty(ae_a), .empty(emp_a));

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(din_b), .wr_en(wr_b), .rd_en(rd_b), .data_out(dout_b),
    .wr_ack(ack_b), .overflow(ovf_b), .underflow(unf_b), .count(cnt_b), .full(full_b),
    .almostfull(af_b), .half_full(hf_b), .almostempty(ae_b), .empty(emp_b));

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  logic [15:0] exp_q[$];
  logic        exp_rd_a = 1'b0;
  logic        fire_a   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a read the bench expects to be accepted presents its word after that edge.
  always @(posedge clk) fire_a = rd_a && exp_rd_a && rst_n;

  always @(negedge clk) begin
    if (fire_a) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_a_data: got %0h expected none (queue empty)", dout_a);
      end else begin
        chk("sb_a_data", 32'(dout_a), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {wr_a, rd_a, wr_b, rd_b} = '0;
    din_a = '0;
    din_b = '0;

    // 1. reset and idle
    step(); step();
    chk("rst_empty", 32'(emp_a), 1);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_dout", 32'(dout_a), 0);
    chk("rst_pulses", 32'({ack_a, ovf_a, unf_a}), 0);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_dout_fwft", 32'(dout_b), 0);
    rst_n = 1'b1;
    step();

    // 2. fill A with 0xA000..0xA007, then overflow
    for (int i = 0; i < 8; i++) begin
      wr_a = 1'b1; din_a = 16'hA000 + 16'(i);
      step();
      chk("fill_ack", 32'(ack_a), 1);
      chk("fill_count", 32'(cnt_a), 32'(i + 1));
      chk("fill_half", 32'(hf_a), 32'(i + 1 >= 4));
      chk("fill_af", 32'(af_a), 32'(i + 1 == 7));
      chk("fill_full", 32'(full_a), 32'(i + 1 == 8));
      chk("fill_ae", 32'(ae_a), 32'(i + 1 == 1));
    end
    din_a = 16'hBEEF;
    step();
    chk("ovf_flag", 32'(ovf_a), 1);
    chk("ovf_ack", 32'(ack_a), 0);
    chk("ovf_count", 32'(cnt_a), 8);
    wr_a = 1'b0;
    step();
    chk("idle_clears", 32'({ack_a, ovf_a, unf_a}), 0);

    // 3. drain A in order, then underflow
    for (int i = 0; i < 8; i++) begin
      rd_a = 1'b1; exp_rd_a = 1'b1;
      exp_q.push_back(16'hA000 + 16'(i));
      step();
      chk("drain_count", 32'(cnt_a), 32'(7 - i));
      chk("drain_ae", 32'(ae_a), 32'(7 - i == 1));
      chk("drain_empty", 32'(emp_a), 32'(7 - i == 0));
    end
    exp_rd_a = 1'b0;
    step();
    chk("unf_flag", 32'(unf_a), 1);
    chk("unf_dout_hold", 32'(dout_a), 32'h0000A007);
    chk("unf_empty", 32'(emp_a), 1);
    rd_a = 1'b0;

    // 4. simultaneous write+read on full, then on empty
    for (int i = 0; i < 8; i++) begin
      wr_a = 1'b1; din_a = 16'hB000 + 16'(i);
      step();
    end
    chk("refill_full", 32'(full_a), 1);
    din_a = 16'h5555; rd_a = 1'b1; exp_rd_a = 1'b1;
    exp_q.push_back(16'hB000);
    step();
    chk("full_rw_ack", 32'(ack_a), 1);
    chk("full_rw_ovf", 32'(ovf_a), 0);
    chk("full_rw_count", 32'(cnt_a), 8);
    wr_a = 1'b0;
    for (int i = 1; i < 8; i++) begin
      exp_q.push_back(16'hB000 + 16'(i));
      step();
    end
    exp_q.push_back(16'h5555);
    step();
    chk("drained_empty", 32'(emp_a), 1);
    exp_rd_a = 1'b0; wr_a = 1'b1; din_a = 16'h7777;
    step();
    chk("empty_rw_count", 32'(cnt_a), 1);
    chk("empty_rw_unf", 32'(unf_a), 1);
    chk("empty_rw_ack", 32'(ack_a), 1);
    wr_a = 1'b0; exp_rd_a = 1'b1;
    exp_q.push_back(16'h7777);
    step();
    rd_a = 1'b0; exp_rd_a = 1'b0;
    step();

    // 5. FWFT behaviour and pointer wrap at depth 5
    wr_b = 1'b1; din_b = 16'h1234;
    step();
    wr_b = 1'b0;
    chk("fwft_empty", 32'(emp_b), 0);
    chk("fwft_dout", 32'(dout_b), 32'h1234);
    rd_b = 1'b1;
    step();
    rd_b = 1'b0;
    chk("fwft_pop_empty", 32'(emp_b), 1);
    chk("fwft_pop_hold", 32'(dout_b), 32'h1234);
    for (int k = 0; k < 12; k++) begin
      wr_b = 1'b1; din_b = 16'hD000 + 16'(k);
      step();
      wr_b = 1'b0;
      chk("wrap_head", 32'(dout_b), 32'(16'hD000 + 16'(k)));
      chk("wrap_count", 32'(cnt_b), 1);
      rd_b = 1'b1;
      step();
      rd_b = 1'b0;
      chk("wrap_empty", 32'(emp_b), 1);
      chk("wrap_hold", 32'(dout_b), 32'(16'hD000 + 16'(k)));
    end
    rd_b = 1'b1;
    step();
    rd_b = 1'b0;
    chk("fwft_unf", 32'(unf_b), 1);

    // 6. asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      wr_a = 1'b1; din_a = 16'hC000 + 16'(i);
      step();
    end
    chk("pre_rst_count", 32'(cnt_a), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(cnt_a), 0);
    chk("async_rst_empty", 32'(emp_a), 1);
    step();
    chk("rst_no_ack", 32'({ack_a, ovf_a, unf_a}), 0);
    chk("rst_hold_count", 32'(cnt_a), 0);
    wr_a = 1'b0;
    rst_n = 1'b1;
    rd_a = 1'b1;
    step();
    rd_a = 1'b0;
    chk("post_rst_unf", 32'(unf_a), 1);
    chk("post_rst_dout", 32'(dout_a), 0);
    step();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
